layer_out_serializer: RTL

- Sits between two fully connected layers.
- Collects the parallel outputs of one layer's NUM_NEURONS neurons and re-emits them as a contiguous serial burst, one word per cycle, on the `myinput`/`myinputValid` pair that feeds every neuron of the next layer.
- Tolerates skewed `outvalid` pulses from the upstream neurons.
- Holds one complete pending set while a burst is in progress.
- Enforces an idle gap between bursts so downstream neurons see a falling edge on valid, finish their bias/activation pipeline and clear their read address.

---
 rtl/layer_out_serializer_if.sv | 23 ++
 rtl/layer_out_serializer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/layer_out_serializer_if.sv
// Bus bundle for layer_out_serializer: parallel neuron outputs in, serial
// myinput/myinputValid stream plus status flags out.
interface layer_out_serializer_if #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 16
);
  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
  logic [NUM_NEURONS-1:0]            in_valid;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_valid;
  logic                              busy;
  logic                              overrun;

  modport master (
    output in_data, in_valid,
    input  out_data, out_valid, busy, overrun
  );

  modport slave (
    input  in_data, in_valid,
    output out_data, out_valid, busy, overrun
  );
endinterface

// File: rtl/layer_out_serializer.sv
// Gathers one layer's parallel neuron outputs (tolerating skewed valids) and
// replays them as a contiguous serial burst, with an enforced idle gap between bursts.
module layer_out_serializer #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int MIN_GAP     = 8
) (
  input logic                    clk,
  input logic                    rst,
  layer_out_serializer_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int GAP_W = $clog2(MIN_GAP) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  cap_data_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]  cap_data_d [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] cap_mask_q, cap_mask_d;
  logic [DATA_WIDTH-1:0]  out_buf_q  [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]  out_buf_d  [NUM_NEURONS];
  logic [IDX_W-1:0]       idx_q, idx_d, idx_nxt_s;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   pending_s, idx_last_s, gap_last_s, transfer_s;
  logic [NUM_NEURONS-1:0] mask_base_s, collide_s;

  assign pending_s  = &cap_mask_q;
  assign idx_last_s = (idx_q == IDX_LAST);
  assign gap_last_s = (gap_cnt_q == GAP_LAST);
  assign idx_nxt_s  = idx_q + IDX_W'(1);
  // The last gap cycle hands over directly so the wire sees exactly MIN_GAP idle cycles.
  assign transfer_s = pending_s & ((state_q == ST_IDLE) | ((state_q == ST_GAP) & gap_last_s));
  // A word arriving on the transfer cycle lands in the freshly cleared mask.
  assign mask_base_s = transfer_s ? {NUM_NEURONS{1'b0}} : cap_mask_q;

  // Capture stage: accept first word per slot, flag repeats as overrun
  always_comb begin
    cap_mask_d = mask_base_s;
    collide_s  = {NUM_NEURONS{1'b0}};
    for (int i = 0; i < NUM_NEURONS; i++) begin
      cap_data_d[i] = cap_data_q[i];
      out_buf_d[i]  = transfer_s ? cap_data_q[i] : out_buf_q[i];
      if (bus.in_valid[i] && !mask_base_s[i]) begin
        cap_data_d[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        cap_mask_d[i] = 1'b1;
      end else if (bus.in_valid[i]) begin
        collide_s[i] = 1'b1;
      end else begin
        collide_s[i] = 1'b0;
      end
    end
    overrun_d = overrun_q | (|collide_s);
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_s) state_d = ST_STREAM;
        else           state_d = ST_IDLE;
      end
      ST_STREAM: begin
        if (idx_last_s) state_d = ST_GAP;
        else            state_d = ST_STREAM;
      end
      ST_GAP: begin
        if (!gap_last_s)    state_d = ST_GAP;
        else if (pending_s) state_d = ST_STREAM;
        else                state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output logic: counters and next values of the registered outputs
  always_comb begin
    idx_d       = idx_q;
    gap_cnt_d   = gap_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = {DATA_WIDTH{1'b0}};
    busy_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (transfer_s) begin
          idx_d       = {IDX_W{1'b0}};
          out_valid_d = 1'b1;
          out_data_d  = cap_data_q[0];
          busy_d      = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_STREAM: begin
        busy_d = 1'b1;
        if (idx_last_s) begin
          gap_cnt_d = {GAP_W{1'b0}};
        end else begin
          idx_d       = idx_nxt_s;
          out_valid_d = 1'b1;
          out_data_d  = out_buf_q[idx_nxt_s];
        end
      end
      ST_GAP: begin
        if (!gap_last_s) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
          busy_d    = 1'b1;
        end else if (transfer_s) begin
          idx_d       = {IDX_W{1'b0}};
          out_valid_d = 1'b1;
          out_data_d  = cap_data_q[0];
          busy_d      = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      default: begin
        idx_d     = {IDX_W{1'b0}};
        gap_cnt_d = {GAP_W{1'b0}};
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_mask_q  <= {NUM_NEURONS{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      gap_cnt_q   <= {GAP_W{1'b0}};
      out_data_q  <= {DATA_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cap_data_q[i] <= {DATA_WIDTH{1'b0}};
        out_buf_q[i]  <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      cap_mask_q  <= cap_mask_d;
      idx_q       <= idx_d;
      gap_cnt_q   <= gap_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cap_data_q[i] <= cap_data_d[i];
        out_buf_q[i]  <= out_buf_d[i];
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
endmodule
